// File: rtl/id_pkg.sv
// id_pkg: opcode/funct constants, forward-select codes and FSM encoding shared by the decode stage.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_HALT    = 6'h3f;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    // codes 0 and 3 both select the register file
    localparam logic [1:0] FWD_M = 2'd1;
    localparam logic [1:0] FWD_W = 2'd2;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // R-type, the two-register branches and stores carry a source operand in rt
    function automatic logic reads_rt(input logic [5:0] op);
        return op == OP_SPECIAL || op == OP_BEQ || op == OP_BNE || op[5:3] == 3'b101;
    endfunction

endpackage

// File: rtl/id_stage_hz_if.sv
// id_stage_hz_if: decode-stage bus between IF/ID, EX/MEM/WB feedback and the ID/EX boundary.
interface id_stage_hz_if #(
    parameter int INST_SZ = 32,
    parameter int REG_SZ  = 5,
    parameter int CTRL_SZ = 18
);
    logic               i_valid_D;
    logic [INST_SZ-1:0] i_instruction_D;
    logic [INST_SZ-1:0] i_npc_D;
    logic [CTRL_SZ-1:0] i_ctrl_D;
    logic [1:0]         i_fwd_a_sel;
    logic [1:0]         i_fwd_b_sel;
    logic [INST_SZ-1:0] i_alu_result_M;
    logic               i_reg_write_E;
    logic               i_mem_read_E;
    logic [REG_SZ-1:0]  i_dst_E;
    logic               i_mem_read_M;
    logic [REG_SZ-1:0]  i_dst_M;
    logic               i_flush;
    logic               i_reg_write_W;
    logic [REG_SZ-1:0]  i_write_register_W;
    logic [INST_SZ-1:0] i_write_data_W;
    logic               o_stall_D;
    logic               o_pc_src_D;
    logic [INST_SZ-1:0] o_target_D;
    logic               o_valid_E;
    logic [INST_SZ-1:0] o_read_data_1_E;
    logic [INST_SZ-1:0] o_read_data_2_E;
    logic [INST_SZ-1:0] o_imm_E;
    logic [REG_SZ-1:0]  o_rs_E;
    logic [REG_SZ-1:0]  o_rt_E;
    logic [REG_SZ-1:0]  o_rd_E;
    logic [CTRL_SZ-1:0] o_ctrl_E;
    logic               o_halted;

    modport master (
        output i_valid_D, i_instruction_D, i_npc_D, i_ctrl_D, i_fwd_a_sel, i_fwd_b_sel,
               i_alu_result_M, i_reg_write_E, i_mem_read_E, i_dst_E, i_mem_read_M, i_dst_M,
               i_flush, i_reg_write_W, i_write_register_W, i_write_data_W,
        input  o_stall_D, o_pc_src_D, o_target_D, o_valid_E, o_read_data_1_E, o_read_data_2_E,
               o_imm_E, o_rs_E, o_rt_E, o_rd_E, o_ctrl_E, o_halted
    );

    modport slave (
        input  i_valid_D, i_instruction_D, i_npc_D, i_ctrl_D, i_fwd_a_sel, i_fwd_b_sel,
               i_alu_result_M, i_reg_write_E, i_mem_read_E, i_dst_E, i_mem_read_M, i_dst_M,
               i_flush, i_reg_write_W, i_write_register_W, i_write_data_W,
        output o_stall_D, o_pc_src_D, o_target_D, o_valid_E, o_read_data_1_E, o_read_data_2_E,
               o_imm_E, o_rs_E, o_rt_E, o_rd_E, o_ctrl_E, o_halted
    );
endinterface

// File: rtl/regfile_bypass.sv
// regfile_bypass: 2-read/1-write register file with write-through, r0 hardwired to zero.
// ID_DEBUG_PORT_EN adds a third combinational read port (i_debug_addr/o_reg).
module regfile_bypass #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_a,
    output logic [DW-1:0] o_rdata_b
`ifdef ID_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0] i_debug_addr,
    output logic [DW-1:0] o_reg
`endif
);
    logic [DW-1:0] r_regs [2**AW];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < 2**AW; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        return a == '0 ? '0 : (i_we && i_waddr == a) ? i_wdata : r_regs[a];
    endfunction

    assign o_rdata_a = rd(i_raddr_a);
    assign o_rdata_b = rd(i_raddr_b);
`ifdef ID_DEBUG_PORT_EN
    assign o_reg = rd(i_debug_addr);
`endif
endmodule

// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS decode with early branch resolution, hazard unit, ID/EX register and halt drain.
// ID_DEBUG_PORT_EN exposes a debug register read (i_debug_addr/o_reg).
module id_stage_hz
    import id_pkg::*;
#(
    parameter int INST_SZ      = 32,
    parameter int REG_SZ       = 5,
    parameter int CTRL_SZ      = 18,
    parameter int DRAIN_CYCLES = 3
) (
    input logic          i_clk,
    input logic          i_reset,
    id_stage_hz_if.slave bus
`ifdef ID_DEBUG_PORT_EN
    ,
    input  logic [REG_SZ-1:0]  i_debug_addr,
    output logic [INST_SZ-1:0] o_reg
`endif
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);

    logic [5:0]         w_op, w_funct;
    logic [REG_SZ-1:0]  w_rs, w_rt, w_rd;
    logic [INST_SZ-1:0] w_imm, w_rf_a, w_rf_b, w_a, w_b;
    logic               w_is_br, w_is_j, w_is_jr, w_is_halt, w_two_op, w_taken;
    logic               w_hz, w_fire, w_issue, w_stall;
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;

    assign w_op    = bus.i_instruction_D[31:26];
    assign w_rs    = bus.i_instruction_D[25:21];
    assign w_rt    = bus.i_instruction_D[20:16];
    assign w_rd    = bus.i_instruction_D[15:11];
    assign w_funct = bus.i_instruction_D[5:0];
    assign w_imm   = {{(INST_SZ-16){bus.i_instruction_D[15]}}, bus.i_instruction_D[15:0]};

    regfile_bypass #(.DW(INST_SZ), .AW(REG_SZ)) u_rf (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (bus.i_reg_write_W),
        .i_waddr   (bus.i_write_register_W),
        .i_wdata   (bus.i_write_data_W),
        .i_raddr_a (w_rs),
        .i_raddr_b (w_rt),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
`ifdef ID_DEBUG_PORT_EN
        ,
        .i_debug_addr (i_debug_addr),
        .o_reg        (o_reg)
`endif
    );

    assign w_a = bus.i_fwd_a_sel == FWD_M ? bus.i_alu_result_M :
                 bus.i_fwd_a_sel == FWD_W ? bus.i_write_data_W : w_rf_a;
    assign w_b = bus.i_fwd_b_sel == FWD_M ? bus.i_alu_result_M :
                 bus.i_fwd_b_sel == FWD_W ? bus.i_write_data_W : w_rf_b;

    assign w_two_op  = w_op == OP_BEQ || w_op == OP_BNE;
    assign w_is_br   = w_two_op || w_op == OP_BLEZ || w_op == OP_BGTZ ||
                       (w_op == OP_REGIMM && w_rt[REG_SZ-1:1] == '0);
    assign w_is_j    = w_op == OP_J || w_op == OP_JAL;
    assign w_is_jr   = w_op == OP_SPECIAL && (w_funct == FN_JR || w_funct == FN_JALR);
    assign w_is_halt = w_op == OP_HALT;

    // REGIMM: rt[0] selects bgez over bltz, so taken is sign XOR rt[0]
    assign w_taken = w_op == OP_BEQ  ? w_a == w_b :
                     w_op == OP_BNE  ? w_a != w_b :
                     w_op == OP_BLEZ ? $signed(w_a) <= 0 :
                     w_op == OP_BGTZ ? $signed(w_a) > 0 : w_rt[0] ^ w_a[INST_SZ-1];

    assign w_hz = (bus.i_mem_read_E && bus.i_dst_E != '0 &&
                   (bus.i_dst_E == w_rs || (reads_rt(w_op) && bus.i_dst_E == w_rt))) ||
                  ((w_is_br || w_is_jr) &&
                   ((bus.i_reg_write_E && bus.i_dst_E != '0 &&
                     (bus.i_dst_E == w_rs || (w_two_op && bus.i_dst_E == w_rt))) ||
                    (bus.i_mem_read_M && bus.i_dst_M != '0 &&
                     (bus.i_dst_M == w_rs || (w_two_op && bus.i_dst_M == w_rt)))));

    assign w_stall = r_state != RUN || (bus.i_valid_D && !bus.i_flush && w_hz);
    assign w_fire  = r_state == RUN && bus.i_valid_D && !bus.i_flush && !w_hz;
    assign w_issue = w_fire && !w_is_halt;

    assign bus.o_stall_D  = w_stall;
    assign bus.o_pc_src_D = w_fire && ((w_is_br && w_taken) || w_is_j || w_is_jr);
    assign bus.o_target_D = w_is_j  ? {bus.i_npc_D[INST_SZ-1:28], bus.i_instruction_D[25:0], 2'b00} :
                            w_is_jr ? w_a : bus.i_npc_D + {w_imm[INST_SZ-3:0], 2'b00};
    assign bus.o_halted   = r_state == HALTED;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_fire && w_is_halt) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = CW'(DRAIN_CYCLES - 1);
        end else if (r_state == DRAIN) begin
            w_state_nxt = r_cnt == '0 ? HALTED : DRAIN;
            w_cnt_nxt   = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // operand/field registers load every cycle; valid and ctrl alone mark a bubble
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bus.o_valid_E       <= 1'b0;
            bus.o_ctrl_E        <= '0;
            bus.o_read_data_1_E <= '0;
            bus.o_read_data_2_E <= '0;
            bus.o_imm_E         <= '0;
            bus.o_rs_E          <= '0;
            bus.o_rt_E          <= '0;
            bus.o_rd_E          <= '0;
        end else begin
            bus.o_valid_E       <= w_issue;
            bus.o_ctrl_E        <= w_issue ? bus.i_ctrl_D : '0;
            bus.o_read_data_1_E <= w_rf_a;
            bus.o_read_data_2_E <= w_rf_b;
            bus.o_imm_E         <= w_imm;
            bus.o_rs_E          <= w_rs;
            bus.o_rt_E          <= w_rt;
            bus.o_rd_E          <= w_rd;
        end
    end
endmodule

// File: tb/tb_id_stage_hz.sv
// tb_id_stage_hz: directed vector table for branch/hazard decode plus sequences for bypass, bubbles and halt drain.
module tb_id_stage_hz;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    id_stage_hz_if bus();

`ifdef ID_DEBUG_PORT_EN
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_reg;
`endif

    id_stage_hz dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
`ifdef ID_DEBUG_PORT_EN
        ,
        .i_debug_addr (dbg_addr),
        .o_reg        (dbg_reg)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [1:0]  fa;
        logic [1:0]  fb;
        int          hk;
        logic [4:0]  hd;
        logic        es;
        logic        ep;
        logic        ct;
        logic [31:0] et;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic valid, logic flush, logic [31:0] instr, logic [31:0] npc,
                                logic [1:0] fa, logic [1:0] fb, int hk, logic [4:0] hd,
                                logic es, logic ep, logic ct, logic [31:0] et);
        vec_t v;
        v.valid = valid; v.flush = flush; v.instr = instr; v.npc = npc;
        v.fa = fa; v.fb = fb; v.hk = hk; v.hd = hd;
        v.es = es; v.ep = ep; v.ct = ct; v.et = et;
        return v;
    endfunction

    function automatic logic [31:0] itp(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rtp(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_valid_D = 0; bus.i_instruction_D = 0; bus.i_npc_D = 0; bus.i_ctrl_D = 0;
        bus.i_fwd_a_sel = 0; bus.i_fwd_b_sel = 0; bus.i_alu_result_M = 0;
        bus.i_reg_write_E = 0; bus.i_mem_read_E = 0; bus.i_dst_E = 0;
        bus.i_mem_read_M = 0; bus.i_dst_M = 0; bus.i_flush = 0;
        bus.i_reg_write_W = 0; bus.i_write_register_W = 0; bus.i_write_data_W = 0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [31:0] d);
        idle();
        bus.i_reg_write_W = 1; bus.i_write_register_W = r; bus.i_write_data_W = d;
        tick();
        bus.i_reg_write_W = 0;
    endtask

    task automatic drive(input vec_t v);
        idle();
        bus.i_valid_D = v.valid; bus.i_flush = v.flush;
        bus.i_instruction_D = v.instr; bus.i_npc_D = v.npc;
        bus.i_fwd_a_sel = v.fa; bus.i_fwd_b_sel = v.fb;
        bus.i_alu_result_M = 32'd1; bus.i_write_data_W = 32'd2;
        bus.i_mem_read_E  = v.hk == 1;
        bus.i_reg_write_E = v.hk == 2;
        bus.i_mem_read_M  = v.hk == 3;
        bus.i_dst_E = (v.hk == 1 || v.hk == 2) ? v.hd : 5'd0;
        bus.i_dst_M = v.hk == 3 ? v.hd : 5'd0;
    endtask

    initial begin
        // register file after preload: r1=1 r2=2 r3=0x30 r4=-5 r31=0x400, rest 0
        vecs.push_back(mk(1, 0, itp(6'd4, 1, 1, 16'd4),      32'h100, 0, 0, 0, 0,  0, 1, 1, 32'h110));
        vecs.push_back(mk(1, 0, itp(6'd4, 1, 2, 16'd4),      32'h100, 0, 0, 0, 0,  0, 0, 1, 32'h110));
        vecs.push_back(mk(1, 0, itp(6'd5, 6, 7, 16'hFFFF),   32'h104, 1, 2, 0, 0,  0, 1, 1, 32'h100));
        vecs.push_back(mk(1, 0, itp(6'd6, 4, 0, 16'd8),      32'h200, 0, 0, 0, 0,  0, 1, 1, 32'h220));
        vecs.push_back(mk(1, 0, itp(6'd6, 1, 0, 16'd8),      32'h200, 0, 0, 0, 0,  0, 0, 1, 32'h220));
        vecs.push_back(mk(1, 0, itp(6'd7, 1, 0, 16'hFFFC),   32'h200, 0, 0, 0, 0,  0, 1, 1, 32'h1F0));
        vecs.push_back(mk(1, 0, itp(6'd7, 0, 0, 16'd4),      32'h200, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, itp(6'd1, 4, 0, 16'd1),      32'h300, 0, 0, 0, 0,  0, 1, 1, 32'h304));
        vecs.push_back(mk(1, 0, itp(6'd1, 4, 1, 16'd1),      32'h300, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(1, 0, itp(6'd1, 0, 1, 16'd2),      32'h300, 0, 0, 0, 0,  0, 1, 1, 32'h308));
        vecs.push_back(mk(1, 0, {6'd2, 26'h40},              32'h10000004, 0, 0, 0, 0, 0, 1, 1, 32'h10000100));
        vecs.push_back(mk(1, 0, {6'd3, 26'h3FFFFFF},         32'hF0000000, 0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFC));
        vecs.push_back(mk(1, 0, rtp(31, 0, 0, 6'h08),        32'h10, 0, 0, 0, 0,   0, 1, 1, 32'h400));
        vecs.push_back(mk(1, 0, rtp(3, 0, 31, 6'h09),        32'h10, 0, 0, 0, 0,   0, 1, 1, 32'h30));
        vecs.push_back(mk(1, 0, rtp(3, 2, 4, 6'h20),         32'h10, 0, 0, 1, 3,   1, 0, 0, 0));
        vecs.push_back(mk(1, 0, rtp(2, 3, 4, 6'h20),         32'h10, 0, 0, 1, 3,   1, 0, 0, 0));
        vecs.push_back(mk(1, 0, itp(6'd8, 1, 3, 16'd5),      32'h10, 0, 0, 1, 3,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, rtp(0, 0, 4, 6'h20),         32'h10, 0, 0, 1, 0,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, itp(6'd4, 1, 2, 16'd4),      32'h100, 0, 0, 2, 2,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, rtp(1, 2, 4, 6'h20),         32'h10, 0, 0, 2, 1,   0, 0, 0, 0));
        vecs.push_back(mk(1, 0, rtp(31, 0, 0, 6'h08),        32'h10, 0, 0, 3, 31,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, itp(6'd5, 1, 2, 16'd4),      32'h100, 0, 0, 3, 2,  1, 0, 0, 0));
        vecs.push_back(mk(1, 1, rtp(3, 2, 4, 6'h20),         32'h10, 0, 0, 1, 3,   0, 0, 0, 0));
        vecs.push_back(mk(1, 1, itp(6'd4, 1, 1, 16'd4),      32'h100, 0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, itp(6'd4, 1, 1, 16'd4),      32'h100, 0, 0, 0, 0,  0, 0, 0, 0));

        idle();
        #1 rst_n = 0;
        #1;
        chk("rst_valid_E", 32'(bus.o_valid_E), 0);
        chk("rst_ctrl_E", 32'(bus.o_ctrl_E), 0);
        chk("rst_rd1_E", bus.o_read_data_1_E, 0);
        chk("rst_halted", 32'(bus.o_halted), 0);
        chk("rst_stall", 32'(bus.o_stall_D), 0);
        tick();
        tick();
        rst_n = 1;
        tick();

        wr(1, 32'd1);
        wr(2, 32'd2);
        wr(3, 32'h30);
        wr(4, 32'hFFFFFFFB);
        wr(31, 32'h400);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(bus.o_stall_D), 32'(vecs[i].es));
            chk($sformatf("vec%0d_pc_src", i), 32'(bus.o_pc_src_D), 32'(vecs[i].ep));
            if (vecs[i].ct) chk($sformatf("vec%0d_target", i), bus.o_target_D, vecs[i].et);
            tick();
        end

        // write-through: r5 written in W while beq r5,r0 decodes
        idle();
        bus.i_reg_write_W = 1; bus.i_write_register_W = 5; bus.i_write_data_W = 32'd7;
        bus.i_valid_D = 1; bus.i_instruction_D = itp(6'd4, 5, 0, 16'd4); bus.i_npc_D = 32'h100;
        bus.i_ctrl_D = 18'h15555;
        #1;
        chk("byp_pc_src", 32'(bus.o_pc_src_D), 0);
        chk("byp_stall", 32'(bus.o_stall_D), 0);
        tick();
        bus.i_reg_write_W = 0;
        chk("byp_rd1_E", bus.o_read_data_1_E, 32'd7);
        chk("byp_valid_E", 32'(bus.o_valid_E), 1);
        chk("byp_ctrl_E", 32'(bus.o_ctrl_E), 32'h15555);
        chk("byp_rs_E", 32'(bus.o_rs_E), 5);

        // load-use: one bubble, then the add issues
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = rtp(3, 2, 4, 6'h20); bus.i_ctrl_D = 18'h2AAAA;
        bus.i_mem_read_E = 1; bus.i_dst_E = 3;
        #1;
        chk("lu_stall1", 32'(bus.o_stall_D), 1);
        tick();
        chk("lu_bubble_valid", 32'(bus.o_valid_E), 0);
        chk("lu_bubble_ctrl", 32'(bus.o_ctrl_E), 0);
        bus.i_mem_read_E = 0; bus.i_dst_E = 0;
        #1;
        chk("lu_stall2", 32'(bus.o_stall_D), 0);
        tick();
        chk("lu_valid_E", 32'(bus.o_valid_E), 1);
        chk("lu_ctrl_E", 32'(bus.o_ctrl_E), 32'h2AAAA);
        chk("lu_rd_E", 32'(bus.o_rd_E), 4);
        chk("lu_rt_E", 32'(bus.o_rt_E), 2);
        chk("lu_rd1_E", bus.o_read_data_1_E, 32'h30);
        chk("lu_rd2_E", bus.o_read_data_2_E, 32'd2);

        // jr r31 behind an EX write to r31
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = rtp(31, 0, 0, 6'h08);
        bus.i_reg_write_E = 1; bus.i_dst_E = 31;
        #1;
        chk("jr_stall", 32'(bus.o_stall_D), 1);
        chk("jr_pc_src_held", 32'(bus.o_pc_src_D), 0);
        tick();
        bus.i_reg_write_E = 0; bus.i_dst_E = 0;
        #1;
        chk("jr_stall_clear", 32'(bus.o_stall_D), 0);
        chk("jr_pc_src", 32'(bus.o_pc_src_D), 1);
        chk("jr_target", bus.o_target_D, 32'h400);
        tick();

        // flush with a load-use hazard: bubble, no stall
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = rtp(3, 2, 4, 6'h20); bus.i_ctrl_D = 18'h3FFFF;
        bus.i_mem_read_E = 1; bus.i_dst_E = 3; bus.i_flush = 1;
        #1;
        chk("fl_stall", 32'(bus.o_stall_D), 0);
        tick();
        chk("fl_valid_E", 32'(bus.o_valid_E), 0);
        chk("fl_ctrl_E", 32'(bus.o_ctrl_E), 0);

        // sign-extended immediate
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = itp(6'd8, 1, 4, 16'hFFFD);
        tick();
        chk("imm_E", bus.o_imm_E, 32'hFFFFFFFD);
        chk("imm_rt_E", 32'(bus.o_rt_E), 4);
        chk("imm_valid_E", 32'(bus.o_valid_E), 1);

        // reset in the middle of DRAIN returns to RUN at once
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = 32'hFC000000;
        #1;
        chk("md_halt_stall", 32'(bus.o_stall_D), 0);
        tick();
        chk("md_drain_stall", 32'(bus.o_stall_D), 1);
        rst_n = 0;
        #1;
        chk("md_reset_stall", 32'(bus.o_stall_D), 0);
        chk("md_reset_halted", 32'(bus.o_halted), 0);
        bus.i_valid_D = 0;
        #1 rst_n = 1;
        tick();

        // full halt drain
        idle();
        bus.i_valid_D = 1; bus.i_instruction_D = 32'hFC000000;
        #1;
        chk("h_stall0", 32'(bus.o_stall_D), 0);
        tick();
        chk("h_bubble", 32'(bus.o_valid_E), 0);
        bus.i_instruction_D = itp(6'd4, 1, 1, 16'd4); bus.i_flush = 1;
        #1;
        chk("h_drain_stall", 32'(bus.o_stall_D), 1);
        chk("h_drain_pc_src", 32'(bus.o_pc_src_D), 0);
        chk("h_drain_halted", 32'(bus.o_halted), 0);
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk($sformatf("h_halted_c%0d", n), 32'(bus.o_halted), 32'(n == 3));
            chk($sformatf("h_stall_c%0d", n), 32'(bus.o_stall_D), 1);
        end
        bus.i_flush = 0; bus.i_instruction_D = {6'd2, 26'h40};
        #1;
        chk("h_halted_pc_src", 32'(bus.o_pc_src_D), 0);
        chk("h_halted_valid_E", 32'(bus.o_valid_E), 0);
        tick();
        chk("h_still_halted", 32'(bus.o_halted), 1);
        rst_n = 0;
        #1;
        chk("h_reset_halted", 32'(bus.o_halted), 0);
        idle();
        tick();
        rst_n = 1;
        #1;
        chk("h_reset_stall", 32'(bus.o_stall_D), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end
endmodule

// File: doc/id_stage_hz.md
# id_stage_hz

Second-generation MIPS decode stage: register file with write-through bypass, early branch/jump resolution across six condition codes, and a built-in hazard unit. Also provides a registered ID/EX boundary with valid/stall/flush handling and a halt-drain state machine. Sits between the IF/ID register and EX; replaces the combinational decode plus the external ID/EX register and hazard logic.

## Interface
- INST_SZ, 32, datapath and instruction width
- REG_SZ, 5, register index width; register file holds 2**REG_SZ entries
- CTRL_SZ, 18, width of the EX/MEM/WB control bundle passed through
- DRAIN_CYCLES, 3, cycles waited after HALT before `o_halted` asserts (≥1)

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid_D  in  1  IF/ID holds a real instruction
- i_instruction_D  in  INST_SZ  instruction in decode
- i_npc_D  in  INST_SZ  PC+4 of that instruction
- i_ctrl_D  in  CTRL_SZ  control bundle from the main control unit
- i_fwd_a_sel, i_fwd_b_sel  in  2  branch-operand source: 0 regfile, 1 `i_alu_result_M`, 2 `i_write_data_W`, 3 regfile
- i_alu_result_M  in  INST_SZ  MEM-stage ALU result
- i_reg_write_E, i_mem_read_E  in  1  EX-stage write/load flags
- i_dst_E  in  REG_SZ  EX-stage destination
- i_mem_read_M  in  1  MEM-stage load flag
- i_dst_M  in  REG_SZ  MEM-stage destination
- i_flush  in  1  squash decode instruction
- i_reg_write_W  in  1  writeback enable
- i_write_register_W  in  REG_SZ  writeback index
- i_write_data_W  in  INST_SZ  writeback data
- o_stall_D  out  1  hold PC and IF/ID
- o_pc_src_D  out  1  redirect fetch to `o_target_D`
- o_target_D  out  INST_SZ  branch/jump/jr target
- o_valid_E  out  1  ID/EX holds a real instruction
- o_read_data_1_E, o_read_data_2_E, o_imm_E  out  INST_SZ  registered operands, sign-extended immediate
- o_rs_E, o_rt_E, o_rd_E  out  REG_SZ  registered fields
- o_ctrl_E  out  CTRL_SZ  registered control bundle
- o_halted  out  1  pipeline drained after HALT

## Operation
- Register file:
  - r0 reads zero; writes to r0 are ignored.
  - A write in W to the register being read returns `i_write_data_W` the same cycle.
- Branch compare on the forwarded operands A and B:
  - beq (op 4): A==B
  - bne (op 5): A!=B
  - blez (op 6): A≤0 signed
  - bgtz (op 7): A>0 signed
  - bltz/bgez (op 1, rt 0/1): A<0 / A≥0
- Targets:
  - branch: npc + (sext(imm)<<2), modulo 2**INST_SZ
  - j/jal (op 2/3): {npc[31:28], instr[25:0], 2'b00}
  - jr/jalr (op 0, funct 8/9): A
- `o_pc_src_D` = fire & (taken branch | jump). fire = i_valid_D & ~o_stall_D & ~i_flush & state==RUN.
- Hazards; stall (`o_stall_D`=1) when any holds:
  - load-use: i_mem_read_E & i_dst_E≠0 & (i_dst_E==rs | (instruction reads rt & i_dst_E==rt))
  - branch/jr after EX write: i_reg_write_E & i_dst_E≠0 & i_dst_E matches a compare operand
  - branch/jr after load in MEM: i_mem_read_M & i_dst_M≠0 & i_dst_M matches a compare operand
- A stall or flush inserts a bubble into ID/EX: valid=0, ctrl=0. Flush has priority over stall; flush never asserts `o_stall_D`.
- FSM:
  - RUN → DRAIN when fire with op 6'b111111 (HALT). HALT itself enters ID/EX as a bubble. Counter loads DRAIN_CYCLES-1.
  - DRAIN: `o_stall_D`=1, bubbles issued, counter decrements; at 0 → HALTED. `i_flush` ignored.
  - HALTED: `o_halted`=1, `o_stall_D`=1, bubbles, `o_pc_src_D`=0; leaves only on reset.

## Timing
- Reset (async assert, sync-free deassert):
  - all registers cleared, state RUN
  - all ID/EX outputs 0, `o_halted`=0
  - `o_stall_D`, `o_pc_src_D`, `o_target_D` combinational
- Register file write occurs on the rising edge; the same-cycle read sees new data via bypass.
- `o_pc_src_D`/`o_target_D` are valid in the decode cycle, zero latency. Fetch redirects next edge.
- ID/EX latency: 1 cycle.
- Stall lasts exactly while the hazard condition holds. A load-use hazard gives exactly one bubble.
- Reset mid-DRAIN returns to RUN immediately.

## Configuration
- `ID_DEBUG_PORT_EN` defined: adds input `i_debug_addr` (REG_SZ) and output `o_reg` (INST_SZ), a combinational read of the register file (r0 reads 0).
- Undefined: both ports absent; no extra read port.

## Structure
- Shared package `id_pkg`:
  - opcode/funct constants (BEQ, BNE, BLEZ, BGTZ, REGIMM, J, JAL, HALT, JR, JALR)
  - FSM state encoding (RUN, DRAIN, HALTED)
  - forward-select encoding
- One sub-module: `regfile_bypass` (2 read ports, optional debug port, write-through).

## Test plan
- Write r5=7 in W while decoding `beq r5,r0` with i_fwd_a_sel=0 → bypass gives A=7, not taken; o_pc_src_D=0.
- Load to r3 in EX, decode `add r4,r3,r2` → one bubble (o_valid_E=0), o_stall_D=1 one cycle, then issues.
- `bne r1,r2,-1` with npc 0x104, A=1, B=2 via fwd sel 1/2 → o_pc_src_D=1, o_target_D=0x100.
- `jr r31` with r31=0x400 and i_reg_write_E, i_dst_E=31 → stall one cycle, then target 0x400.
- HALT with DRAIN_CYCLES=3 → stall from next cycle; o_halted=1 three cycles after; flush ignored meanwhile; reset clears it.
- i_flush and load-use hazard together → bubble, o_stall_D=0.
